// File: rtl/sdrc_arb_pkg.sv
// rtl/sdrc_arb_pkg.sv - shared types and helpers for the sdrc application-port arbiter
package sdrc_arb_pkg;

    typedef enum logic [2:0] {IDLE, REQ, WR, RD, DONE} arb_state_e;

    localparam int NREQ_MAX = 8;
    localparam int IDX_W    = $clog2(NREQ_MAX);

    // Explicit wrap so non-power-of-2 requester counts cycle correctly.
    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] ptr, input int n);
        if (int'(ptr) >= n - 1)
            return '0;
        else
            return ptr + 1'b1;
    endfunction

endpackage

// File: rtl/sdrc_rr_picker.sv
// rtl/sdrc_rr_picker.sv - combinational round-robin pick: first set request at or after ptr, wrapping
module sdrc_rr_picker
    import sdrc_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] idx
);

    logic found;

    // First pass covers ptr..NREQ-1, second pass wraps to 0..ptr-1.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i] && (IDX_W'(i) >= ptr)) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                idx      = IDX_W'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i]) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                idx      = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/sdrc_app_arbiter.sv
// rtl/sdrc_app_arbiter.sv - round-robin share of the sdrc_core app port, one transaction outstanding
// Optional: SDRC_ARB_HIPRI_EN makes requester 0 strict high priority.
module sdrc_app_arbiter
    import sdrc_arb_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int APP_AW = 26,
    parameter int bl     = 9,
    parameter int dw     = 32
) (
    input  logic                     sdram_clk,
    input  logic                     sdram_reset,
    input  logic [NREQ-1:0]          rq_req,
    input  logic [NREQ*APP_AW-1:0]   rq_addr,
    input  logic [NREQ*bl-1:0]       rq_len,
    input  logic [NREQ-1:0]          rq_wr_n,
    input  logic [NREQ*dw-1:0]       rq_wr_data,
    input  logic [NREQ*(dw/8)-1:0]   rq_wr_en_n,
    output logic [NREQ-1:0]          rq_ack,
    output logic [NREQ-1:0]          rq_wr_next,
    output logic [NREQ-1:0]          rq_rd_valid,
    output logic [NREQ-1:0]          rq_last,
    output logic [dw-1:0]            rq_rd_data,
    output logic                     app_req,
    output logic [APP_AW-1:0]        app_req_addr,
    output logic [bl-1:0]            app_req_len,
    output logic                     app_req_wr_n,
    output logic [dw-1:0]            app_wr_data,
    output logic [dw/8-1:0]          app_wr_en_n,
    input  logic                     app_req_ack,
    input  logic                     app_wr_next_req,
    input  logic                     app_rd_valid,
    input  logic                     app_last_rd,
    input  logic                     app_last_wr,
    input  logic [dw-1:0]            app_rd_data,
    output logic                     busy
);

    localparam int BW = dw / 8;

    arb_state_e        state, state_nxt;
    logic [IDX_W-1:0]  owner, rr_ptr, pick_idx, rr_idx;
    logic [NREQ-1:0]   pick_req, rr_grant;
    logic              pick_valid;
    logic [APP_AW-1:0] pick_addr;
    logic [bl-1:0]     pick_len;
    logic              pick_wr_n;
    logic [bl-1:0]     beat_cnt;
    logic              err_len;
    logic              beat, last_beat, len_out;

    sdrc_rr_picker #(.NREQ(NREQ)) u_picker (
        .req   (pick_req),
        .ptr   (rr_ptr),
        .grant (rr_grant),
        .idx   (rr_idx)
    );

`ifdef SDRC_ARB_HIPRI_EN
    assign pick_req   = {rq_req[NREQ-1:1], 1'b0};
    assign pick_valid = rq_req[0] | (|rr_grant);
    assign pick_idx   = rq_req[0] ? '0 : rr_idx;
`else
    assign pick_req   = rq_req;
    assign pick_valid = |rr_grant;
    assign pick_idx   = rr_idx;
`endif

    always_comb begin
        pick_addr = '0;
        pick_len  = '0;
        pick_wr_n = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                pick_addr = rq_addr[i*APP_AW +: APP_AW];
                pick_len  = rq_len[i*bl +: bl];
                pick_wr_n = rq_wr_n[i];
            end
        end
    end

    assign beat      = ((state == WR) && app_wr_next_req) || ((state == RD) && app_rd_valid);
    assign last_beat = ((state == WR) && app_wr_next_req && app_last_wr) ||
                       ((state == RD) && app_rd_valid && app_last_rd);
    // Length ran out without the core flagging the last beat.
    assign len_out   = beat && !last_beat && (beat_cnt <= bl'(1));

    always_ff @(posedge sdram_clk or posedge sdram_reset) begin
        if (sdram_reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        app_req     = 1'b0;
        busy        = (state != IDLE);
        app_wr_data = '0;
        app_wr_en_n = '1;
        rq_ack      = '0;
        rq_wr_next  = '0;
        rq_rd_valid = '0;
        rq_last     = '0;
        rq_rd_data  = (state == RD) ? app_rd_data : '0;
        case (state)
            IDLE: if (pick_valid) state_nxt = REQ;
            REQ: begin
                app_req = 1'b1;
                if (app_req_ack) state_nxt = app_req_wr_n ? RD : WR;
            end
            WR, RD:   if (last_beat || len_out) state_nxt = DONE;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
        for (int i = 0; i < NREQ; i++) begin
            if (owner == IDX_W'(i)) begin
                rq_ack[i]      = (state == REQ) && app_req_ack;
                rq_wr_next[i]  = (state == WR) && app_wr_next_req;
                rq_rd_valid[i] = (state == RD) && app_rd_valid;
                rq_last[i]     = last_beat;
                if (state == WR) begin
                    app_wr_data = rq_wr_data[i*dw +: dw];
                    app_wr_en_n = rq_wr_en_n[i*BW +: BW];
                end
            end
        end
    end

    always_ff @(posedge sdram_clk or posedge sdram_reset) begin
        if (sdram_reset) begin
            owner        <= '0;
            rr_ptr       <= '0;
            app_req_addr <= '0;
            app_req_len  <= '0;
            app_req_wr_n <= 1'b0;
            beat_cnt     <= '0;
            err_len      <= 1'b0;
        end else begin
            err_len <= err_len | len_out;
            case (state)
                IDLE: if (pick_valid) begin
                    owner        <= pick_idx;
                    app_req_addr <= pick_addr;
                    app_req_len  <= pick_len;
                    app_req_wr_n <= pick_wr_n;
                end
                REQ:     if (app_req_ack) beat_cnt <= app_req_len;
                WR, RD:  if (beat) beat_cnt <= beat_cnt - 1'b1;
                DONE: begin
`ifdef SDRC_ARB_HIPRI_EN
                    if (owner != '0) rr_ptr <= rr_next(owner, NREQ);
`else
                    rr_ptr <= rr_next(owner, NREQ);
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sdrc_app_arbiter.sv
// tb/tb_sdrc_app_arbiter.sv - directed self-checking bench for sdrc_app_arbiter (NREQ=4 and NREQ=3)
module tb_sdrc_app_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [3:0]    r4_req, r4_wr_n;
    logic [103:0]  r4_addr;
    logic [35:0]   r4_len;
    logic [127:0]  r4_wd;
    logic [15:0]   r4_be;
    logic [3:0]    o4_ack, o4_wnx, o4_rv, o4_last;
    logic [31:0]   o4_rdd, a4_wd;
    logic          a4_req, a4_wr_n, b4;
    logic [25:0]   a4_addr;
    logic [8:0]    a4_len;
    logic [3:0]    a4_be;

    logic [2:0]    r3_req, r3_wr_n;
    logic [77:0]   r3_addr;
    logic [26:0]   r3_len;
    logic [95:0]   r3_wd;
    logic [11:0]   r3_be;
    logic [2:0]    o3_ack, o3_wnx, o3_rv, o3_last;
    logic [31:0]   o3_rdd, a3_wd;
    logic          a3_req, a3_wr_n, b3;
    logic [25:0]   a3_addr;
    logic [8:0]    a3_len;
    logic [3:0]    a3_be;

    logic          c_ack, c_wnx, c_rv, c_lrd, c_lwr;
    logic [31:0]   c_rdd;

    sdrc_app_arbiter #(.NREQ(4)) dut4 (
        .sdram_clk(clk), .sdram_reset(rst),
        .rq_req(r4_req), .rq_addr(r4_addr), .rq_len(r4_len), .rq_wr_n(r4_wr_n),
        .rq_wr_data(r4_wd), .rq_wr_en_n(r4_be),
        .rq_ack(o4_ack), .rq_wr_next(o4_wnx), .rq_rd_valid(o4_rv), .rq_last(o4_last),
        .rq_rd_data(o4_rdd),
        .app_req(a4_req), .app_req_addr(a4_addr), .app_req_len(a4_len), .app_req_wr_n(a4_wr_n),
        .app_wr_data(a4_wd), .app_wr_en_n(a4_be),
        .app_req_ack(c_ack), .app_wr_next_req(c_wnx), .app_rd_valid(c_rv),
        .app_last_rd(c_lrd), .app_last_wr(c_lwr), .app_rd_data(c_rdd),
        .busy(b4)
    );

    sdrc_app_arbiter #(.NREQ(3)) dut3 (
        .sdram_clk(clk), .sdram_reset(rst),
        .rq_req(r3_req), .rq_addr(r3_addr), .rq_len(r3_len), .rq_wr_n(r3_wr_n),
        .rq_wr_data(r3_wd), .rq_wr_en_n(r3_be),
        .rq_ack(o3_ack), .rq_wr_next(o3_wnx), .rq_rd_valid(o3_rv), .rq_last(o3_last),
        .rq_rd_data(o3_rdd),
        .app_req(a3_req), .app_req_addr(a3_addr), .app_req_len(a3_len), .app_req_wr_n(a3_wr_n),
        .app_wr_data(a3_wd), .app_wr_en_n(a3_be),
        .app_req_ack(c_ack), .app_wr_next_req(c_wnx), .app_rd_valid(c_rv),
        .app_last_rd(c_lrd), .app_last_wr(c_lwr), .app_rd_data(c_rdd),
        .busy(b3)
    );

    task automatic set_cmd(input int len, input bit wr);
        for (int i = 0; i < 4; i++) begin
            r4_len[i*9 +: 9] = 9'(len);
            r4_wr_n[i]       = !wr;
        end
        for (int i = 0; i < 3; i++) begin
            r3_len[i*9 +: 9] = 9'(len);
            r3_wr_n[i]       = !wr;
        end
    endtask

    // Plays sdrc_core for one transaction; drop: 0 keep, 1 clear owner's req at ack, 2 clear all.
    task automatic serve(input bit d3, input int exp, input int beats, input bit wr, input int drop);
        int n;
        logic [3:0] v, one;
        one = 4'b0001 << exp;
        n = 0;
        while (!(d3 ? a3_req : a4_req) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("app_req", d3 ? a3_req : a4_req, 1);
        check("addr", d3 ? a3_addr : a4_addr, (d3 ? 26'h2000 : 26'h1000) + 26'(exp));
        check("len", d3 ? a3_len : a4_len, beats);
        check("wr_n", d3 ? a3_wr_n : a4_wr_n, !wr);
        c_ack = 1'b1;
        #1;
        v = d3 ? {1'b0, o3_ack} : o4_ack;
        check("ack", v, one);
        if (drop == 1) begin
            r4_req = d3 ? r4_req : (r4_req & ~one);
            r3_req = d3 ? (r3_req & ~one[2:0]) : r3_req;
        end else if (drop == 2) begin
            r4_req = d3 ? r4_req : 4'b0;
            r3_req = d3 ? 3'b0 : r3_req;
        end
        @(posedge clk); #1;
        c_ack = 1'b0;
        check("req_fall", d3 ? a3_req : a4_req, 0);
        for (int b = 0; b < beats; b++) begin
            if (wr) begin
                c_wnx = 1'b1;
                c_lwr = (b == beats - 1);
            end else begin
                c_rv  = 1'b1;
                c_lrd = (b == beats - 1);
                c_rdd = 32'hD0D0_0000 + 32'(exp * 16 + b);
            end
            #1;
            if (wr) v = d3 ? {1'b0, o3_wnx} : o4_wnx;
            else    v = d3 ? {1'b0, o3_rv} : o4_rv;
            check("strobe", v, one);
            v = d3 ? {1'b0, o3_last} : o4_last;
            check("last", v, (b == beats - 1) ? one : 4'b0);
            if (wr) begin
                check("wdata", d3 ? a3_wd : a4_wd, 32'hCAFE_0000 + 32'(exp));
                check("wen", d3 ? a3_be : a4_be, 4'(exp + 4));
            end else begin
                check("rdata0", d3 ? o3_rdd : o4_rdd, 32'hD0D0_0000 + 32'(exp * 16 + b));
            end
            @(posedge clk); #1;
            c_wnx = 1'b0; c_lwr = 1'b0; c_rv = 1'b0; c_lrd = 1'b0;
        end
        check("busy_done", d3 ? b3 : b4, 1);
        @(posedge clk); #1;
        check("busy_idle", d3 ? b3 : b4, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        r4_req = '0; r3_req = '0;
        c_ack = 0; c_wnx = 0; c_rv = 0; c_lrd = 0; c_lwr = 0; c_rdd = '0;
        for (int i = 0; i < 4; i++) begin
            r4_addr[i*26 +: 26] = 26'h1000 + 26'(i);
            r4_wd[i*32 +: 32]   = 32'hCAFE_0000 + 32'(i);
            r4_be[i*4 +: 4]     = 4'(i + 4);
        end
        for (int i = 0; i < 3; i++) begin
            r3_addr[i*26 +: 26] = 26'h2000 + 26'(i);
            r3_wd[i*32 +: 32]   = 32'hCAFE_0000 + 32'(i);
            r3_be[i*4 +: 4]     = 4'(i + 4);
        end
        set_cmd(2, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst_app_req", a4_req, 0);
        check("rst_busy", b4, 0);
        check("rst_addr", a4_addr, 0);
        check("rst_wen", a4_be, 4'hF);
        check("rst_wdata", a4_wd, 0);
        check("rst_rq", {o4_ack, o4_wnx, o4_rv, o4_last}, 0);

        // contention, all reads of 2 beats
        r4_req = 4'b1111;
        serve(0, 0, 2, 0, 0);
        serve(0, 1, 2, 0, 0);
        serve(0, 2, 2, 0, 0);
        serve(0, 3, 2, 0, 0);
        serve(0, 0, 2, 0, 2);

        // single write of 4 beats, grant latency 1 cycle
        set_cmd(4, 1);
        r4_req = 4'b0001;
        #1 check("pre_grant", a4_req, 0);
        @(posedge clk); #1;
        check("grant_lat", a4_req, 1);
        serve(0, 0, 4, 1, 1);

        // hold rule: requester 2 drops its request during REQ
        set_cmd(2, 1);
        r4_req = 4'b0100;
        @(posedge clk); #1;
        r4_req = 4'b0000;
        serve(0, 2, 2, 1, 0);

        // NREQ=3 wrap: owner 1 leaves rr_ptr=2, then 0 and 1
        set_cmd(1, 0);
        r3_req = 3'b010;
        serve(1, 1, 1, 0, 1);
        r3_req = 3'b011;
        serve(1, 0, 1, 0, 1);
        serve(1, 1, 1, 0, 1);

        // reset on beat 3 of an 8-beat read
        set_cmd(8, 0);
        r4_req = 4'b0001;
        @(posedge clk); #1;
        c_ack = 1'b1;
        @(posedge clk); #1;
        c_ack = 1'b0; r4_req = 4'b0;
        c_rv = 1'b1; c_rdd = 32'h1234_5678;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #1 check("pre_rst_rv", o4_rv, 4'b0001);
        rst = 1'b1;
        #1;
        check("arst_rv", o4_rv, 0);
        check("arst_last", o4_last, 0);
        check("arst_busy", b4, 0);
        check("arst_app_req", a4_req, 0);
        check("arst_len", a4_len, 0);
        check("arst_rdata", o4_rdd, 0);
        check("arst_wen", a4_be, 4'hF);
        c_rv = 1'b0; c_rdd = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        // rr_ptr was 3 before reset; reset value 0 must pick requester 0 first
        set_cmd(1, 0);
        r4_req = 4'b1001;
        serve(0, 0, 1, 0, 1);
        serve(0, 3, 1, 0, 1);

        // requester 0 raised during requester 1's transfer
        r4_req = 4'b1110;
        @(posedge clk); #1;
        r4_req = 4'b1111;
        serve(0, 1, 1, 0, 0);
`ifdef SDRC_ARB_HIPRI_EN
        serve(0, 0, 1, 0, 1);
        serve(0, 2, 1, 0, 2);
`else
        serve(0, 2, 1, 0, 0);
        serve(0, 3, 1, 0, 0);
        serve(0, 0, 1, 0, 2);
`endif
        repeat (3) @(posedge clk);
        #1 check("final_idle", b4, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
